banco_reg: RTL
==============

Name: banco_reg

Overview:
- 32 x 32-bit MIPS general-purpose register file for the multicycle datapath.
- Sits directly downstream of the write-register selector (rt / 29 / 31 / rd). Its 5-bit output drives write_reg here.
- Read ports feed registers A and B. The write port is fed by the MemToReg data mux.
- Holds $sp ($29) initialised to the stack top and hardwires $zero.

Parameters:
- DATA_W, 32, register width in bits.
- SP_INIT, 32'd227, reset value of register 29 ($sp).
- SP_IDX, 5'd29, index of the stack pointer register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable from the control unit.
- read_reg1  input  5  rs index for read port 1.
- read_reg2  input  5  rt index for read port 2.
- write_reg  input  5  destination index, from the write-register selector.
- write_data  input  DATA_W  data to store.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Storage: 32 entries of DATA_W bits.
- Reset:
  - Asserting reset immediately, without a clock edge, clears every entry to 0 except entry SP_IDX, which loads SP_INIT.
  - While reset is high, read_data1 = read_data2 = 0 unless the addressed index is SP_IDX, which reads SP_INIT.
  - Reset has priority over any write in the same cycle.
- Write: on the rising edge of clk with reset=0 and reg_write=1, entry[write_reg] <= write_data.
  - Writes to index 0 are discarded; entry 0 always reads 0.
  - reg_write=0 leaves all entries unchanged.
  - Write latency is 1 clock: data is visible on the read ports after the edge.
- Read: combinational (zero latency).
  - read_data1 = entry[read_reg1]; read_data2 = entry[read_reg2].
  - Both ports may address the same index simultaneously and return identical data.
- Same-cycle read and write of the same index (no bypass build): read port returns the OLD value until the clock edge, then the new value.
- Reset released mid-cycle: no write occurs until the next rising edge with reg_write=1.
- X/undriven write_reg while reg_write=0 must not corrupt storage.
- Width: write_data stored as-is; no sign or zero extension performed here.

Optional Feature:
- Macro: BANCO_REG_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. When reg_write=1, write_reg!=0 and write_reg equals read_reg1 (or read_reg2), the matching read port combinationally returns write_data in the same cycle, before the edge.
  - Reset still forces reset values and overrides the bypass.
  - Bypass never applies to index 0.
- Undefined: no forwarding; read ports reflect stored contents only, as described in Behaviour.

Test Plan:
- Reset: assert reset for 2 cycles, then read indices 0, 5, 29, 31 -> 0, 0, 227, 0. Also assert reset asynchronously between edges and check read_data updates without a clock edge.
- Basic write/read: reg_write=1, write_reg=8, write_data=32'hDEADBEEF, one edge; read_reg1=8 -> 32'hDEADBEEF.
  - Then reg_write=0, write_data=32'h1 for one edge -> still 32'hDEADBEEF.
- $zero protection: write 32'hFFFFFFFF to index 0 -> read_data1 and read_data2 at index 0 are 0.
- Selector-driven indices:
  - write 32'h00000010 to 31 ($ra) -> reads 32'h10.
  - write 32'd200 to 29 -> reads 200.
  - assert reset -> index 29 reads 227 and index 31 reads 0.
- Same-cycle read/write on index 12 (old 5, new 9):
  - before the edge, read_data2 = 5 without bypass, 9 with BANCO_REG_BYPASS_EN.
  - after the edge, 9 in both builds.
- Dual-port sweep: write i*3 to each index 1..31; read all pairs (i, 31-i) -> expected values, with index 0 reading 0.

Source files
------------

// File: rtl/banco_reg.sv
// 32 x DATA_W MIPS register file: two combinational read ports, one write port, hardwired $zero, $sp reset to SP_INIT.
// Define BANCO_REG_BYPASS_EN to forward write_data to a matching read port in the same cycle.
module banco_reg #(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'd227,
  parameter logic [4:0]       SP_IDX  = 5'd29
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] regs [0:31];

  // Storage: async reset loads reset values; index 0 is never written so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i[4:0] == SP_IDX) begin
          regs[i] <= SP_INIT;
        end else begin
          regs[i] <= '0;
        end
      end
    end else if (reg_write && (write_reg != 5'd0)) begin
      regs[write_reg] <= write_data;
    end
  end

  // Read port 1: $zero first, then optional forwarding (suppressed during reset), then storage.
  always_comb begin
    read_data1 = '0;
    if (read_reg1 == 5'd0) begin
      read_data1 = '0;
`ifdef BANCO_REG_BYPASS_EN
    end else if (!reset && reg_write && (write_reg == read_reg1)) begin
      read_data1 = write_data;
`endif
    end else begin
      read_data1 = regs[read_reg1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    read_data2 = '0;
    if (read_reg2 == 5'd0) begin
      read_data2 = '0;
`ifdef BANCO_REG_BYPASS_EN
    end else if (!reset && reg_write && (write_reg == read_reg2)) begin
      read_data2 = write_data;
`endif
    end else begin
      read_data2 = regs[read_reg2];
    end
  end

endmodule
